// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch block: FSM states, fetch-queue entry, NOP encoding.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fq_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_if.sv
// Memory-side and decode-side signal bundle of the fetch sequencer.
// The out_fault member exists only when FETCH_FAULT_EN is defined.
interface fetch_if #(
  parameter int FQ_DEPTH = 4
);
  logic                      fetch_en;
  logic [31:0]               imem_addr;
  logic [31:0]               imem_data;
  logic                      redirect_valid;
  logic [31:0]               redirect_pc;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_pc;
  logic [31:0]               out_instr;
  logic [$clog2(FQ_DEPTH):0] fq_count;
`ifdef FETCH_FAULT_EN
  logic                      out_fault;
`endif

  modport master (
    input  fetch_en, imem_data, redirect_valid, redirect_pc, out_ready,
    output imem_addr, out_valid, out_pc, out_instr, fq_count
`ifdef FETCH_FAULT_EN
    , output out_fault
`endif
  );

  modport slave (
    output fetch_en, imem_data, redirect_valid, redirect_pc, out_ready,
    input  imem_addr, out_valid, out_pc, out_instr, fq_count
`ifdef FETCH_FAULT_EN
    , input out_fault
`endif
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous fetch queue of fq_entry_t; flush overrides push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fq_entry_t              push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fq_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t      mem_q [DEPTH];
  fq_entry_t      mem_d [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push is about to take, so full+pop still accepts a push.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the pc, fills the fetch queue and handles redirects.
// Optional FETCH_FAULT_EN adds out_fault and a FAULT state for misaligned/out-of-range pcs.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FQ_DEPTH   = 4,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0 || IMEM_WORDS < 1) begin : g_bad_params
    $error("fetch_ctrl: FQ_DEPTH must be a power of 2 >= 2 and IMEM_WORDS >= 1");
  end

  fetch_state_t              state_q, state_d;
  logic [31:0]               pc_q, pc_d;
  fq_entry_t                 push_entry;
  fq_entry_t                 head;
  logic                      full, empty, pop, push_ok;
  logic [$clog2(FQ_DEPTH):0] count;

  assign pop     = !empty && bus.out_ready;
  assign push_ok = (state_q == FETCH) && bus.fetch_en && !bus.redirect_valid && (!full || pop);

`ifdef FETCH_FAULT_EN
  logic pc_bad;
  assign pc_bad = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS));
`endif

  // A redirect overrides both the normal state transition and the pc increment.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    push_entry = '{pc: pc_q, instr: bus.imem_data, fault: 1'b0};
    case (state_q)
      IDLE:    if (bus.fetch_en)  state_d = FETCH;
      FETCH:   if (!bus.fetch_en) state_d = IDLE;
      default: state_d = state_q;
    endcase
    if (push_ok) begin
`ifdef FETCH_FAULT_EN
      if (pc_bad) begin
        push_entry.instr = NOP_INSTR;
        push_entry.fault = 1'b1;
        state_d          = FAULT;
      end else begin
        pc_d = pc_q + 32'd4;
      end
`else
      pc_d = pc_q + 32'd4;
`endif
    end
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      state_d = bus.fetch_en ? FETCH : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = !empty;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;
  assign bus.fq_count  = count;
`ifdef FETCH_FAULT_EN
  assign bus.out_fault = head.fault;
`else
  logic unused_fault;
  assign unused_fault = head.fault;
`endif

endmodule
